// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-serial fetch/data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        D_RD  = 2'd2,
        D_WR  = 2'd3
    } state_t;

    // Transfer size codes; the reserved code behaves as a full word.
    localparam logic [1:0] LEN_B   = 2'b00;
    localparam logic [1:0] LEN_H   = 2'b01;
    localparam logic [1:0] LEN_RSV = 2'b10;
    localparam logic [1:0] LEN_W   = 2'b11;

    // Fetches are never started into the IO window selected by these bits.
    localparam int         IO_SEL_HI  = 17;
    localparam int         IO_SEL_LO  = 16;
    localparam logic [1:0] IO_SEL_VAL = 2'b11;

    // Sequencer state kept as one struct so checkers can bind to a single signal.
    typedef struct packed {
        state_t     state;
        state_t     op;
        logic       fin;
        logic [2:0] cnt;
    } seq_t;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] len_mask(input logic [1:0] len);
        case (len)
            LEN_B:   return 32'h0000_00FF;
            LEN_H:   return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_byte_assembler.sv
// Four-lane byte register; word shows the lanes with the pending lane write merged in.
module byte_assembler (
    input  logic        clk,
    input  logic        clr,
    input  logic        we,
    input  logic [1:0]  lane,
    input  logic [7:0]  din,
    output logic [31:0] word
);

    logic [31:0] lanes_q;

    always_comb begin
        word = lanes_q;
        for (int i = 0; i < 4; i++) begin
            if (we && lane == 2'(i)) word[i*8 +: 8] = din;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) lanes_q <= '0;
        else     lanes_q <= word;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto a byte-wide RAM/IO bus, one byte per cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_PRIO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_len,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    localparam bit DPRIO = (DATA_PRIO != 0);

    seq_t        seq_q, seq_n;
    logic [31:0] base_q, wdata_q, if_data_q, d_rdata_q, word;
    logic [1:0]  len_q, cap_lane;
    logic [2:0]  n_bytes;
    logic        io_fetch, fin_fetch, fin_data, if_ok, d_ok, pick_d, pick_if;
    logic        accept, cap, ld_done;

    assign n_bytes   = len_bytes(len_q);
    assign io_fetch  = (if_addr[IO_SEL_HI:IO_SEL_LO] == IO_SEL_VAL);
    assign fin_fetch = seq_q.fin && (seq_q.op == IF_RD);
    assign fin_data  = seq_q.fin && (seq_q.op != IF_RD);

    // The port completing in this cycle still holds its request; it must not win again.
    assign if_ok   = if_req && !if_flush && !io_fetch && !fin_fetch;
    assign d_ok    = d_req && !fin_data;
    assign pick_d  = d_ok && (DPRIO || !if_ok);
    assign pick_if = if_ok && !pick_d;

    assign if_done = fin_fetch && rdy && !rst && !if_flush;
    assign d_done  = fin_data && rdy && !rst;
    assign ld_done = d_done && (seq_q.op == D_RD);

    // The byte addressed last cycle is on mem_din now and lands in lane cnt-1.
    assign cap      = rdy && !rst && (seq_q.cnt != 3'd0) &&
                      ((seq_q.state == IF_RD && !if_flush) || seq_q.state == D_RD ||
                       (seq_q.fin && seq_q.op != D_WR));
    assign cap_lane = 2'(seq_q.cnt - 3'd1);

    always_comb begin
        seq_n  = seq_q;
        accept = 1'b0;
        if (rdy) begin
            if (seq_q.fin) begin
                seq_n.fin = 1'b0;
                seq_n.cnt = 3'd0;
            end
            unique case (seq_q.state)
                IDLE: begin
                    if (pick_d || pick_if) begin
                        accept      = 1'b1;
                        seq_n.state = pick_d ? (d_we ? D_WR : D_RD) : IF_RD;
                        seq_n.op    = seq_n.state;
                        seq_n.cnt   = 3'd0;
                        seq_n.fin   = 1'b0;
                    end
                end
                IF_RD, D_RD, D_WR: begin
                    if (seq_q.state == IF_RD && if_flush) begin
                        seq_n.state = IDLE;
                        seq_n.cnt   = 3'd0;
                    end else begin
                        seq_n.cnt = seq_q.cnt + 3'd1;
                        if (seq_q.cnt == n_bytes - 3'd1) begin
                            seq_n.state = IDLE;
                            seq_n.fin   = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // While paused a read keeps addressing the byte still owed to the lanes,
    // so mem_din carries it again when rdy returns.
    always_comb begin
        mem_a    = '0;
        mem_wr   = 1'b0;
        mem_dout = '0;
        unique case (seq_q.state)
            IF_RD, D_RD: begin
                if (rdy) mem_a = base_q + 32'(seq_q.cnt);
                else     mem_a = base_q + 32'(seq_q.cnt) - 32'(seq_q.cnt != 3'd0);
            end
            D_WR: begin
                mem_a  = base_q + 32'(seq_q.cnt);
                mem_wr = rdy;
                for (int i = 0; i < 4; i++) begin
                    if (seq_q.cnt[1:0] == 2'(i)) mem_dout = wdata_q[i*8 +: 8];
                end
            end
            IDLE: begin
                if (seq_q.fin && !rdy && seq_q.op != D_WR) mem_a = base_q + 32'(seq_q.cnt - 3'd1);
            end
        endcase
    end

    assign if_data = if_done ? word : if_data_q;
    assign d_rdata = ld_done ? (word & len_mask(len_q)) : d_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q     <= '{state: IDLE, op: IDLE, fin: 1'b0, cnt: 3'd0};
            base_q    <= '0;
            len_q     <= LEN_B;
            wdata_q   <= '0;
            if_data_q <= '0;
            d_rdata_q <= '0;
        end else begin
            seq_q <= seq_n;
            if (accept) begin
                base_q  <= pick_d ? d_addr : if_addr;
                len_q   <= pick_d ? d_len : LEN_W;
                wdata_q <= d_wdata;
            end
            if (if_done) if_data_q <= word;
            if (ld_done) d_rdata_q <= word & len_mask(len_q);
        end
    end

    byte_assembler u_lanes (
        .clk  (clk),
        .clr  (rst || accept),
        .we   (cap),
        .lane (cap_lane),
        .din  (mem_din),
        .word (word)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed corner cases plus random traffic.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_data;
  logic        d_req, d_we, d_done;
  logic [1:0]  d_len;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_vec = 0;
  int n_bad = 0;

  logic [39:0] wr_q[$];
  logic [31:0] if_exp_q[$];
  logic [31:0] d_exp_q[$];
  logic [31:0] last_if = '0;
  logic [31:0] last_d = '0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .d_req(d_req), .d_we(d_we), .d_len(d_len), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // RAM model: one cycle read latency, contents derived from the address
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a, input int nb);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < nb; k++) w[k*8 +: 8] = ram_byte(a + 32'(k));
    return w;
  endfunction

  always @(posedge clk) mem_din <= ram_byte(mem_a);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard: pops expectations whenever the DUT writes or completes
  always @(negedge clk) begin
    logic [39:0] w;
    if (mem_wr === 1'b1) begin
      if (wr_q.size() == 0) check("wr_unexp", 32'(mem_wr), 32'd0);
      else begin
        w = wr_q.pop_front();
        check("wr_addr", mem_a, w[39:8]);
        check("wr_byte", 32'(mem_dout), 32'(w[7:0]));
      end
    end
    if (if_done === 1'b1) begin
      if (if_exp_q.size() == 0) check("if_unexp", 32'(if_done), 32'd0);
      else check("if_data", if_data, if_exp_q.pop_front());
    end
    if (d_done === 1'b1) begin
      if (d_exp_q.size() == 0) check("d_unexp", 32'(d_done), 32'd0);
      else check("d_rdata", d_rdata, d_exp_q.pop_front());
    end
    if (if_done === 1'b1 || d_done === 1'b1) check("done_excl", 32'(if_done & d_done), 32'd0);
  end

  // driver tasks: called just after a rising edge with the DUT idle
  task automatic do_data(input logic we, input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] wdata, input int pause_at, input int plen);
    int nb;
    int lat;
    logic [31:0] exp;
    nb  = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    lat = 0;
    if (we) begin
      for (int k = 0; k < nb; k++) wr_q.push_back({addr + 32'(k), wdata[k*8 +: 8]});
      exp = last_d;
    end else begin
      exp    = rd_word(addr, nb);
      last_d = exp;
    end
    d_exp_q.push_back(exp);
    d_req = 1'b1; d_we = we; d_len = len; d_addr = addr; d_wdata = wdata;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (pause_at != 0 && k == pause_at) rdy = 1'b0;
      if (pause_at != 0 && k == pause_at + plen) rdy = 1'b1;
      @(negedge clk);
      if (pause_at == 0 && k <= nb) check("d_addr", mem_a, addr + 32'(k - 1));
      if (pause_at != 0 && k >= pause_at && k < pause_at + plen) check("pause_wr", 32'(mem_wr), 32'd0);
      if (pause_at != 0 && k == pause_at + plen) check("resume_a", mem_a, addr + 32'(pause_at - 1));
      if (d_done) begin
        lat = k;
        break;
      end
    end
    check("d_lat", 32'(lat), 32'(nb + 1 + plen));
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] addr);
    int lat;
    logic [31:0] exp;
    lat = 0;
    exp = rd_word(addr, 4);
    if_exp_q.push_back(exp);
    last_if = exp;
    if_req = 1'b1; if_addr = addr;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (k <= 4) check("if_addr", mem_a, addr + 32'(k - 1));
      if (if_done) begin
        lat = k;
        break;
      end
    end
    check("if_lat", 32'(lat), 32'd5);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  initial begin
    int dl, il;
    rst = 1'b1; rdy = 1'b1;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_len = 2'b00; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_if_done", 32'(if_done), 32'd0);
    check("rst_d_done", 32'(d_done), 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic fetch: bytes 10..13 give 0x13121110
    do_fetch(32'h0000_0010);
    check("fetch_word", last_if, 32'h1312_1110);

    // simultaneous requests, data wins, fetch follows after one idle cycle
    wr_q.push_back({32'h0000_0100, 8'hB6});
    wr_q.push_back({32'h0000_0101, 8'hA5});
    d_exp_q.push_back(last_d);
    if_exp_q.push_back(rd_word(32'h0000_0200, 4));
    last_if = rd_word(32'h0000_0200, 4);
    d_req = 1'b1; d_we = 1'b1; d_len = 2'b01; d_addr = 32'h0000_0100; d_wdata = 32'h0000_A5B6;
    if_req = 1'b1; if_addr = 32'h0000_0200;
    dl = 0; il = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 4) d_req = 1'b0;
      @(negedge clk);
      if (k == 1) check("arb_d_first", mem_a, 32'h0000_0100);
      if (k == 4) check("arb_if_next", mem_a, 32'h0000_0200);
      if (d_done) dl = k;
      if (if_done) begin
        il = k;
        break;
      end
    end
    check("arb_d_lat", 32'(dl), 32'd3);
    check("arb_if_lat", 32'(il), 32'd8);
    @(posedge clk); #1;
    if_req = 1'b0;

    // flush during cycle 3 of a fetch
    if_req = 1'b1; if_addr = 32'h0000_0040;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 3) if_flush = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    if_flush = 1'b0; if_req = 1'b0;
    @(negedge clk);
    check("flush_mem_a", mem_a, 32'd0);
    check("flush_if_data", if_data, last_if);
    repeat (6) @(negedge clk);
    check("flush_keep", if_data, last_if);
    @(posedge clk); #1;

    // fetch into IO space is held off until the address leaves it
    if_req = 1'b1; if_addr = 32'h0003_0040;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("io_hold", mem_a, 32'd0);
    end
    do_fetch(32'h0004_0040);

    // load with a three-cycle pause at byte 2
    do_data(1'b0, 2'b11, 32'h0003_0000, 32'h0, 3, 3);

    // address wrap
    do_data(1'b0, 2'b11, 32'hFFFF_FFFE, 32'h0, 0, 0);

    // short loads and reserved length
    do_data(1'b0, 2'b00, 32'h0000_1234, 32'h0, 0, 0);
    do_data(1'b0, 2'b01, 32'h0000_5671, 32'h0, 0, 0);
    do_data(1'b0, 2'b10, 32'h0000_9AB0, 32'h0, 0, 0);

    // paused store
    do_data(1'b1, 2'b11, 32'h0000_0700, 32'hDEAD_BEEF, 2, 2);

    // random traffic
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 3) == 0) do_fetch($urandom() & 32'hFFFD_FFFF);
      else do_data(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom(), $urandom(), 0, 0);
    end

    // reset during the second byte of a store
    wr_q.push_back({32'h0000_0500, 8'h44});
    wr_q.push_back({32'h0000_0501, 8'h33});
    d_req = 1'b1; d_we = 1'b1; d_len = 2'b11; d_addr = 32'h0000_0500; d_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstw_a1", mem_a, 32'h0000_0500);
    @(posedge clk); #1;
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    check("rstw_wr2", 32'(mem_wr), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstw_mem_wr", 32'(mem_wr), 32'd0);
    check("rstw_mem_a", mem_a, 32'd0);
    check("rstw_mem_dout", 32'(mem_dout), 32'd0);
    check("rstw_d_done", 32'(d_done), 32'd0);
    check("rstw_if_data", if_data, 32'd0);
    check("rstw_d_rdata", d_rdata, 32'd0);
    repeat (6) @(negedge clk);

    check("wr_left", 32'(wr_q.size()), 32'd0);
    check("if_left", 32'(if_exp_q.size()), 32'd0);
    check("d_left", 32'(d_exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
